// File: rtl/seq_det_sched.sv
// Round-robin scheduler sharing one serial "01" detector among N_REQ requesters; done is raised FRAME_LEN+3 cycles after a grant request.
// Build macro SEQ_SCHED_FIXED_PRIO_EN switches arbitration to fixed priority (lowest set req index wins, no RR pointer).
module seq_det_sched #(
  parameter int N_REQ     = 4,
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] din_i,
  input  logic             det_y_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic             det_x_o,
  output logic             det_clr_o,
  output logic [N_REQ-1:0] done_o,
  output logic [CNT_W-1:0] match_cnt_o,
  output logic             busy_o
);
  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BEAT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, REPORT} state_t;

  state_t            state_q;
  logic [IDX_W-1:0]  win_q;
  logic [BEAT_W-1:0] beat_q;
  logic [N_REQ-1:0]  gnt_q;
  logic [N_REQ-1:0]  done_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              clr_q;
  logic              busy_q;

  logic [IDX_W-1:0]  win_d;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  cnt_d;
  logic              abort;

`ifndef SEQ_SCHED_FIXED_PRIO_EN
  logic [IDX_W-1:0]  ptr_q;
`endif

  // Scan from the far end so the highest-priority candidate is written last.
  always_comb begin
    win_d = '0;
    idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
`ifdef SEQ_SCHED_FIXED_PRIO_EN
      idx = IDX_W'(k);
`else
      idx = IDX_W'((int'(ptr_q) + 1 + k) % N_REQ);
`endif
      if (req_i[idx]) win_d = idx;
    end
  end

  assign cnt_d = (det_y_i && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
  assign abort = ~req_i[win_q];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      win_q   <= '0;
      beat_q  <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      cnt_q   <= '0;
      clr_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifndef SEQ_SCHED_FIXED_PRIO_EN
      ptr_q   <= IDX_W'(N_REQ - 1);
`endif
    end else begin
      done_q <= '0;
      clr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req_i) begin
            state_q <= CLEAR;
            win_q   <= win_d;
            gnt_q   <= N_REQ'(1) << win_d;
            clr_q   <= 1'b1;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
`ifndef SEQ_SCHED_FIXED_PRIO_EN
            ptr_q   <= win_d;
`endif
          end
        end
        CLEAR: begin
          beat_q  <= '0;
          state_q <= RUN;
        end
        RUN: begin
          cnt_q  <= cnt_d;
          beat_q <= beat_q + BEAT_W'(1);
          if (beat_q == LAST_BEAT) state_q <= DRAIN;
        end
        DRAIN: begin
          cnt_q   <= cnt_d;
          done_q  <= gnt_q;
          state_q <= REPORT;
        end
        REPORT: begin
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      // A dropped request abandons the frame; the trailing clear resets the detector for the next owner.
      if ((state_q inside {CLEAR, RUN, DRAIN}) && abort) begin
        state_q <= IDLE;
        gnt_q   <= '0;
        done_q  <= '0;
        cnt_q   <= '0;
        clr_q   <= 1'b1;
        busy_q  <= 1'b0;
      end
    end
  end

  assign det_x_o     = (state_q == RUN) ? din_i[win_q] : 1'b1;
  assign gnt_o       = gnt_q;
  assign det_clr_o   = clr_q;
  assign done_o      = done_q;
  assign match_cnt_o = cnt_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_seq_det_sched.sv
// Bench for seq_det_sched: randomized frames checked against a frame-level model of arbitration and match counting.
module tb_seq_det_sched;
  localparam int N  = 4;
  localparam int F  = 16;
  localparam int CW = 10;
  localparam int SW = 3;
  localparam int YW = F + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [N-1:0]  req, din;
  logic          det_y;
  logic [N-1:0]  gnt, done, s_gnt, s_done;
  logic          det_x, det_clr, busy, s_det_x, s_det_clr, s_busy;
  logic [CW-1:0] match_cnt;
  logic [SW-1:0] s_match_cnt;

  seq_det_sched #(.N_REQ(N), .FRAME_LEN(F), .CNT_W(CW)) u_dut (
    .clk_i(clk), .rst_i(rst_n), .req_i(req), .din_i(din), .det_y_i(det_y),
    .gnt_o(gnt), .det_x_o(det_x), .det_clr_o(det_clr), .done_o(done),
    .match_cnt_o(match_cnt), .busy_o(busy));

  seq_det_sched #(.N_REQ(N), .FRAME_LEN(F), .CNT_W(SW)) u_sat (
    .clk_i(clk), .rst_i(rst_n), .req_i(req), .din_i(din), .det_y_i(det_y),
    .gnt_o(s_gnt), .det_x_o(s_det_x), .det_clr_o(s_det_clr), .done_o(s_done),
    .match_cnt_o(s_match_cnt), .busy_o(s_busy));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int last_w;

  typedef struct {
    logic [N-1:0]  gnt_clr;
    logic          clr_clr;
    logic          busy_clr;
    logic [CW-1:0] cnt_clr;
    logic          clr_run;
    int            dx_bad;
    logic [N-1:0]  done_early;
    logic [N-1:0]  done_rep;
    logic [CW-1:0] cnt_rep;
    logic [SW-1:0] scnt_rep;
    int            req_cyc;
    int            grant_cyc;
    int            done_cyc;
    logic [N-1:0]  gnt_end;
    logic [N-1:0]  done_end;
    logic          busy_end;
    logic          clr_end;
    logic          dx_end;
    logic [CW-1:0] cnt_end;
    logic [SW-1:0] scnt_end;
  } obs_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration: first requester found when searching from last winner + 1.
  function automatic int pick(input logic [N-1:0] r, input int last);
    int w = -1;
`ifdef SEQ_SCHED_FIXED_PRIO_EN
    for (int i = 0; i < N; i++)
      if (w < 0 && r[i]) w = i;
`else
    for (int k = 1; k <= N; k++)
      if (w < 0 && r[(last + k) % N]) w = (last + k) % N;
`endif
    return w;
  endfunction

  function automatic logic [N-1:0] onehot(input int w);
    return N'(1) << w;
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // Drives one frame starting from an IDLE cycle; stop_beat >= 0 drops req (or asserts reset) at that RUN beat.
  task automatic run_frame(input logic [N-1:0] rq, input int w, input logic [F:0] ymask, input bit din_alt,
                           input int stop_beat, input bit stop_rst, output obs_t o);
    bit stopped = 1'b0;
    o = '{default: '0};
    req   = rq;
    det_y = 1'b1;
    o.req_cyc = cyc;
    tick();
    o.gnt_clr   = gnt;
    o.clr_clr   = det_clr;
    o.busy_clr  = busy;
    o.cnt_clr   = match_cnt;
    o.grant_cyc = cyc;
    o.done_early |= done;
    if (det_x !== 1'b1) o.dx_bad++;
    tick();
    o.clr_run = det_clr;
    for (int b = 0; b < F; b++) begin
      o.done_early |= done;
      din = din_alt ? {N{b[0]}} : N'($urandom);
      #1;
      if (det_x !== din[w]) o.dx_bad++;
      det_y = ymask[b];
      if (b == stop_beat) begin
        if (stop_rst) rst_n = 1'b0;
        else          req[w] = 1'b0;
        stopped = 1'b1;
        break;
      end
      tick();
    end
    if (!stopped) begin
      o.done_early |= done;
      if (det_x !== 1'b1) o.dx_bad++;
      det_y = ymask[F];
      tick();
      o.done_rep = done;
      o.cnt_rep  = match_cnt;
      o.scnt_rep = s_match_cnt;
      o.done_cyc = cyc;
      det_y = 1'b0;
    end
    tick();
    o.gnt_end  = gnt;
    o.done_end = done;
    o.busy_end = busy;
    o.clr_end  = det_clr;
    o.dx_end   = det_x;
    o.cnt_end  = match_cnt;
    o.scnt_end = s_match_cnt;
    det_y = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; din = '0; det_y = 1'b0;
    repeat (3) tick();
    checks++;
    if ({gnt, done, det_clr, busy, det_x, match_cnt} !== {N'(0), N'(0), 1'b0, 1'b0, 1'b1, CW'(0)}) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b done=%b clr=%b busy=%b det_x=%b cnt=%0d expected 0/0/0/0/1/0",
               gnt, done, det_clr, busy, det_x, match_cnt);
    end
    rst_n = 1'b1;
    repeat (2) tick();
    checks++;
    if (busy !== 1'b0 || gnt !== '0) begin
      errors++;
      $display("FAIL reset_idle_no_req: busy=%b gnt=%b expected 0/0", busy, gnt);
    end
    last_w = N - 1;
  endtask

  task automatic test_rr_back_to_back();
    obs_t o;
    int prev_grant = 0;
    logic [F:0] ym;
    for (int i = 0; i < 5; i++) begin
      int w = pick(4'b1111, last_w);
      last_w = w;
      ym = YW'($urandom);
      run_frame(4'b1111, w, ym, 1'b0, -1, 1'b0, o);
      checks++;
      if (o.gnt_clr !== onehot(w)) begin
        errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", i, o.gnt_clr, onehot(w));
      end
      checks++;
      if (o.done_rep !== onehot(w)) begin
        errors++; $display("FAIL rr_done[%0d]: got %b expected %b", i, o.done_rep, onehot(w));
      end
      checks++;
      if (o.cnt_rep !== CW'($countones(ym))) begin
        errors++; $display("FAIL rr_cnt[%0d]: got %0d expected %0d", i, o.cnt_rep, $countones(ym));
      end
      checks++;
      if (o.dx_bad != 0) begin
        errors++; $display("FAIL rr_det_x[%0d]: %0d bad beats expected 0", i, o.dx_bad);
      end
      if (i > 0) begin
        checks++;
        if (o.grant_cyc - prev_grant != F + 4) begin
          errors++; $display("FAIL rr_spacing[%0d]: got %0d expected %0d", i, o.grant_cyc - prev_grant, F + 4);
        end
      end
      prev_grant = o.grant_cyc;
    end
  endtask

  task automatic test_basic();
    obs_t o;
    logic [F:0] ym = 17'h1007F;
    int w = pick(4'b0001, last_w);
    int exp_cnt = $countones(ym);
    last_w = w;
    run_frame(4'b0001, w, ym, 1'b1, -1, 1'b0, o);
    checks++;
    if (o.gnt_clr !== onehot(w)) begin
      errors++; $display("FAIL basic_gnt: got %b expected %b", o.gnt_clr, onehot(w));
    end
    checks++;
    if ({o.clr_clr, o.clr_run} !== 2'b10) begin
      errors++; $display("FAIL basic_det_clr_pulse: got %b%b expected 10", o.clr_clr, o.clr_run);
    end
    checks++;
    if (o.busy_clr !== 1'b1 || o.cnt_clr !== '0) begin
      errors++; $display("FAIL basic_clear_state: busy=%b cnt=%0d expected 1/0", o.busy_clr, o.cnt_clr);
    end
    checks++;
    if (o.dx_bad != 0) begin
      errors++; $display("FAIL basic_det_x: %0d bad beats expected 0", o.dx_bad);
    end
    checks++;
    if (o.done_early !== '0) begin
      errors++; $display("FAIL basic_done_early: got %b expected 0", o.done_early);
    end
    checks++;
    if (o.done_rep !== onehot(w)) begin
      errors++; $display("FAIL basic_done: got %b expected %b", o.done_rep, onehot(w));
    end
    checks++;
    if (o.done_cyc - o.req_cyc != F + 3) begin
      errors++; $display("FAIL basic_latency: got %0d expected %0d", o.done_cyc - o.req_cyc, F + 3);
    end
    checks++;
    if (o.cnt_rep !== CW'(exp_cnt)) begin
      errors++; $display("FAIL basic_match_cnt: got %0d expected %0d", o.cnt_rep, exp_cnt);
    end
    checks++;
    if (o.scnt_rep !== SW'(sat(exp_cnt, 7))) begin
      errors++; $display("FAIL basic_sat_cnt: got %0d expected %0d", o.scnt_rep, sat(exp_cnt, 7));
    end
    checks++;
    if (o.gnt_end !== '0 || o.busy_end !== 1'b0 || o.done_end !== '0) begin
      errors++; $display("FAIL basic_after_report: gnt=%b busy=%b done=%b expected 0/0/0", o.gnt_end, o.busy_end, o.done_end);
    end
  endtask

  task automatic test_abort();
    obs_t o;
    int w = pick(4'b0100, last_w);
    int w2;
    last_w = w;
    run_frame(4'b0100, w, '1, 1'b0, 5, 1'b0, o);
    checks++;
    if (o.busy_end !== 1'b0 || o.gnt_end !== '0) begin
      errors++; $display("FAIL abort_idle: busy=%b gnt=%b expected 0/0", o.busy_end, o.gnt_end);
    end
    checks++;
    if (o.clr_end !== 1'b1) begin
      errors++; $display("FAIL abort_det_clr: got %b expected 1", o.clr_end);
    end
    checks++;
    if (o.cnt_end !== '0) begin
      errors++; $display("FAIL abort_match_cnt: got %0d expected 0", o.cnt_end);
    end
    checks++;
    if (o.done_end !== '0 || o.done_early !== '0) begin
      errors++; $display("FAIL abort_no_done: got %b/%b expected 0", o.done_early, o.done_end);
    end
    checks++;
    if (o.dx_end !== 1'b1) begin
      errors++; $display("FAIL abort_det_x: got %b expected 1", o.dx_end);
    end
    w2 = pick(4'b1011, last_w);
    last_w = w2;
    run_frame(4'b1011, w2, '0, 1'b0, -1, 1'b0, o);
    checks++;
    if (o.gnt_clr !== onehot(w2)) begin
      errors++; $display("FAIL abort_next_gnt: got %b expected %b", o.gnt_clr, onehot(w2));
    end
    checks++;
    if (o.done_rep !== onehot(w2) || o.cnt_rep !== '0) begin
      errors++; $display("FAIL abort_next_done: done=%b cnt=%0d expected %b/0", o.done_rep, o.cnt_rep, onehot(w2));
    end
  endtask

  task automatic test_saturate();
    obs_t o;
    logic [N-1:0] rq = N'($urandom_range(1, (1 << N) - 1));
    int w = pick(rq, last_w);
    last_w = w;
    run_frame(rq, w, '1, 1'b0, -1, 1'b0, o);
    checks++;
    if (o.scnt_rep !== SW'(7)) begin
      errors++; $display("FAIL sat_cnt3: got %0d expected 7", o.scnt_rep);
    end
    checks++;
    if (o.cnt_rep !== CW'(F + 1)) begin
      errors++; $display("FAIL sat_cnt10: got %0d expected %0d", o.cnt_rep, F + 1);
    end
    checks++;
    if (o.done_rep !== onehot(w)) begin
      errors++; $display("FAIL sat_done: got %b expected %b", o.done_rep, onehot(w));
    end
  endtask

  task automatic test_reset_mid_frame();
    obs_t o;
    int w = pick(4'b1111, last_w);
    last_w = w;
    run_frame(4'b1111, w, '1, 1'b0, 10, 1'b1, o);
    last_w = N - 1;
    checks++;
    if ({o.gnt_end, o.done_end, o.clr_end, o.busy_end, o.dx_end, o.cnt_end} !==
        {N'(0), N'(0), 1'b0, 1'b0, 1'b1, CW'(0)}) begin
      errors++;
      $display("FAIL midrst_outputs: gnt=%b done=%b clr=%b busy=%b det_x=%b cnt=%0d expected 0/0/0/0/1/0",
               o.gnt_end, o.done_end, o.clr_end, o.busy_end, o.dx_end, o.cnt_end);
    end
    checks++;
    if (o.done_early !== '0 || o.scnt_end !== '0) begin
      errors++; $display("FAIL midrst_no_done: done=%b scnt=%0d expected 0/0", o.done_early, o.scnt_end);
    end
    w = pick(4'b1111, last_w);
    last_w = w;
    run_frame(4'b1111, w, '0, 1'b0, -1, 1'b0, o);
    checks++;
    if (o.gnt_clr !== onehot(w)) begin
      errors++; $display("FAIL midrst_first_gnt: got %b expected %b", o.gnt_clr, onehot(w));
    end
  endtask

  task automatic test_prio();
    obs_t o;
    for (int i = 0; i < 4; i++) begin
      int w = pick(4'b0110, last_w);
      last_w = w;
      run_frame(4'b0110, w, '0, 1'b0, -1, 1'b0, o);
      checks++;
      if (o.gnt_clr !== onehot(w)) begin
        errors++; $display("FAIL prio_gnt[%0d]: got %b expected %b", i, o.gnt_clr, onehot(w));
      end
    end
  endtask

  task automatic test_random();
    obs_t o;
    for (int i = 0; i < 8; i++) begin
      logic [N-1:0] rq = N'($urandom_range(1, (1 << N) - 1));
      logic [F:0]   ym = YW'($urandom);
      int w = pick(rq, last_w);
      int stop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, F - 1)) : -1;
      last_w = w;
      run_frame(rq, w, ym, 1'b0, stop, 1'b0, o);
      checks++;
      if (o.gnt_clr !== onehot(w) || o.dx_bad != 0) begin
        errors++; $display("FAIL rand_gnt[%0d]: gnt=%b dx_bad=%0d expected %b/0", i, o.gnt_clr, o.dx_bad, onehot(w));
      end
      checks++;
      if (stop < 0) begin
        if (o.done_rep !== onehot(w) || o.cnt_rep !== CW'($countones(ym)) ||
            o.scnt_rep !== SW'(sat($countones(ym), 7))) begin
          errors++;
          $display("FAIL rand_report[%0d]: done=%b cnt=%0d scnt=%0d expected %b/%0d/%0d", i, o.done_rep,
                   o.cnt_rep, o.scnt_rep, onehot(w), $countones(ym), sat($countones(ym), 7));
        end
      end else begin
        if (o.busy_end !== 1'b0 || o.clr_end !== 1'b1 || o.cnt_end !== '0 || o.done_end !== '0) begin
          errors++;
          $display("FAIL rand_abort[%0d]: busy=%b clr=%b cnt=%0d done=%b expected 0/1/0/0", i, o.busy_end,
                   o.clr_end, o.cnt_end, o.done_end);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_rr_back_to_back();
    test_basic();
    test_abort();
    test_saturate();
    test_reset_mid_frame();
    test_prio();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
